uart_script_responder: RTL and testbench

UART_SCRIPT_RESPONDER -- requirements
Module: uart_script_responder

---
 rtl/uart_script_responder_if.sv | 28 ++
 rtl/uart_script_responder.sv | 191 +++++++++++++++++++
 tb/tb_uart_script_responder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_script_responder_if.sv
// uart_script_responder_if
// Groups the byte-receiver and byte-transmitter handshake signals that the
// script responder talks to.
//   rx_ready  receiver holds a byte
//   rx_data   received byte
//   rx_clear  one-cycle pulse that consumes the receiver byte
//   tx_busy   transmitter busy (rises the cycle after tx_start)
//   tx_start  one-cycle transmit request
//   tx_data   byte to send, valid while tx_start=1
// master: the responder side; slave: the UART side.
interface uart_script_responder_if;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_clear;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (
        input  rx_ready, rx_data, tx_busy,
        output rx_clear, tx_start, tx_data
    );

    modport slave (
        output rx_ready, rx_data, tx_busy,
        input  rx_clear, tx_start, tx_data
    );
endinterface

// File: rtl/uart_script_responder.sv
// uart_script_responder
// Waits for a trigger byte (optionally followed by an argument byte) on the
// receiver and answers with a fixed script on the transmitter: ACK_BYTE, the
// ADDR word and the LEN word (both little-endian), then FILL_BYTE repeated
// FILL_COUNT times (forever when FILL_COUNT=0).
// Ports:
//   clk       sole clock
//   rst       synchronous active-high reset
//   enable    0 = received bytes are discarded while idle
//   abort     terminates a response in progress
//   uart      receiver/transmitter handshake (master modport)
//   busy      response in progress
//   done      one-cycle pulse when a finite response completes
//   fill_cnt  fill bytes issued in the current response (saturating)
module uart_script_responder #(
    parameter logic [7:0]  TRIG_BYTE   = 8'h2E,
    parameter bit          ARG_EN      = 1'b0,
    parameter logic [7:0]  ARG_BYTE    = 8'h00,
    parameter int unsigned ARG_TIMEOUT = 50000,
    parameter logic [7:0]  ACK_BYTE    = 8'h44,
    parameter logic [31:0] ADDR        = 32'h8010_0000,
    parameter logic [31:0] LEN         = 32'h0000_1000,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF,
    parameter logic [15:0] FILL_COUNT  = 16'd0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           abort,
    uart_script_responder_if.master        uart,
    output logic                           busy,
    output logic                           done,
    output logic [15:0]                    fill_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ARG,
        SEND_HDR,
        SEND_FILL,
        DONE
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(ARG_TIMEOUT) - 32'd1;
    localparam logic [15:0] FILL_LAST    = FILL_COUNT - 16'd1;

    state_t      state_q, state_d;
    logic [3:0]  hdr_idx_q, hdr_idx_d;
    logic [1:0]  space_q, space_d;
    logic [31:0] timeout_q, timeout_d;
    logic        rx_clear_q, rx_clear_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] fill_cnt_q, fill_cnt_d;
    logic        rx_take;
    logic        can_issue;

    function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    hdr_byte = ACK_BYTE;
            4'd1:    hdr_byte = ADDR[7:0];
            4'd2:    hdr_byte = ADDR[15:8];
            4'd3:    hdr_byte = ADDR[23:16];
            4'd4:    hdr_byte = ADDR[31:24];
            4'd5:    hdr_byte = LEN[7:0];
            4'd6:    hdr_byte = LEN[15:8];
            4'd7:    hdr_byte = LEN[23:16];
            default: hdr_byte = LEN[31:24];
        endcase
    endfunction

    // The receiver keeps rx_ready high until it has seen rx_clear, so a byte
    // is only taken when no clear is already outstanding; otherwise the same
    // byte would be consumed twice (e.g. the trigger mistaken for the argument).
    // space_q blocks issuing for the two cycles after each tx_start so that
    // starts are never closer than three cycles apart.
    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        space_d    = (space_q != 2'd0) ? space_q - 2'd1 : 2'd0;
        timeout_d  = 32'd0;
        rx_clear_d = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        fill_cnt_d = fill_cnt_q;
        rx_take    = uart.rx_ready && !rx_clear_q;
        can_issue  = !uart.tx_busy && (space_q == 2'd0);

        case (state_q)
            IDLE: begin
                if (rx_take) begin
                    rx_clear_d = 1'b1;
                    if (enable && uart.rx_data == TRIG_BYTE) begin
                        fill_cnt_d = 16'd0;
                        hdr_idx_d  = 4'd0;
                        state_d    = ARG_EN ? WAIT_ARG : SEND_HDR;
                    end
                end
            end
            WAIT_ARG: begin
                rx_clear_d = rx_take;
                if (abort) begin
                    state_d = IDLE;
                end else if (rx_take) begin
                    state_d = (uart.rx_data == ARG_BYTE) ? SEND_HDR : IDLE;
                end else if (timeout_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                end else begin
                    timeout_d = timeout_q + 32'd1;
                end
            end
            SEND_HDR: begin
                rx_clear_d = rx_take;
                if (abort) begin
                    state_d = IDLE;
                end else if (can_issue) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = hdr_byte(hdr_idx_q);
                    space_d    = 2'd2;
                    if (hdr_idx_q == 4'd8) begin
                        state_d = SEND_FILL;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 4'd1;
                    end
                end
            end
            SEND_FILL: begin
                rx_clear_d = rx_take;
                if (abort) begin
                    state_d = IDLE;
                end else if (can_issue) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = FILL_BYTE;
                    space_d    = 2'd2;
                    if (fill_cnt_q != 16'hFFFF) begin
                        fill_cnt_d = fill_cnt_q + 16'd1;
                    end
                    if (FILL_COUNT != 16'd0 && fill_cnt_q == FILL_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // busy and done follow the next state so they line up with state_q
        busy_d = (state_d == WAIT_ARG) || (state_d == SEND_HDR) || (state_d == SEND_FILL);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hdr_idx_q  <= 4'd0;
            space_q    <= 2'd0;
            timeout_q  <= 32'd0;
            rx_clear_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fill_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            hdr_idx_q  <= hdr_idx_d;
            space_q    <= space_d;
            timeout_q  <= timeout_d;
            rx_clear_q <= rx_clear_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    assign uart.rx_clear = rx_clear_q;
    assign uart.tx_start = tx_start_q;
    assign uart.tx_data  = tx_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign fill_cnt      = fill_cnt_q;

endmodule

// File: tb/tb_uart_script_responder.sv
// tb_uart_script_responder
// Three responder instances share one stimulus set; sel routes the receiver
// input to one of them and picks which one's outputs are observed.
//   dut 0: defaults, FILL_COUNT=3
//   dut 1: ARG_EN=1, FILL_COUNT=3
//   dut 2: defaults, FILL_COUNT=0 (unbounded)
module tb_uart_script_responder;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        abort;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_busy;
    logic [1:0]  sel;

    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [15:0] fill0, fill1, fill2;

    logic        rx_clear_m;
    logic        tx_start_m;
    logic [7:0]  tx_data_m;
    logic        busy_m;
    logic        done_m;
    logic [15:0] fill_m;

    uart_script_responder_if u_if0 ();
    uart_script_responder_if u_if1 ();
    uart_script_responder_if u_if2 ();

    assign u_if0.rx_ready = rx_ready && (sel == 2'd0);
    assign u_if1.rx_ready = rx_ready && (sel == 2'd1);
    assign u_if2.rx_ready = rx_ready && (sel == 2'd2);
    assign u_if0.rx_data  = rx_data;
    assign u_if1.rx_data  = rx_data;
    assign u_if2.rx_data  = rx_data;
    assign u_if0.tx_busy  = tx_busy;
    assign u_if1.tx_busy  = tx_busy;
    assign u_if2.tx_busy  = tx_busy;

    uart_script_responder #(.FILL_COUNT(16'd3)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .abort(abort),
        .uart(u_if0), .busy(busy0), .done(done0), .fill_cnt(fill0)
    );

    uart_script_responder #(.ARG_EN(1'b1), .FILL_COUNT(16'd3)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .abort(abort),
        .uart(u_if1), .busy(busy1), .done(done1), .fill_cnt(fill1)
    );

    uart_script_responder #(.FILL_COUNT(16'd0)) u_dut2 (
        .clk(clk), .rst(rst), .enable(enable), .abort(abort),
        .uart(u_if2), .busy(busy2), .done(done2), .fill_cnt(fill2)
    );

    always_comb begin
        case (sel)
            2'd1: begin
                rx_clear_m = u_if1.rx_clear; tx_start_m = u_if1.tx_start;
                tx_data_m = u_if1.tx_data; busy_m = busy1; done_m = done1; fill_m = fill1;
            end
            2'd2: begin
                rx_clear_m = u_if2.rx_clear; tx_start_m = u_if2.tx_start;
                tx_data_m = u_if2.tx_data; busy_m = busy2; done_m = done2; fill_m = fill2;
            end
            default: begin
                rx_clear_m = u_if0.rx_clear; tx_start_m = u_if0.tx_start;
                tx_data_m = u_if0.tx_data; busy_m = busy0; done_m = done0; fill_m = fill0;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: records every transmitted byte and counts done/rx_clear pulses
    // and start-spacing violations on the selected instance.
    logic [7:0] stream[$];
    int         done_count  = 0;
    int         clear_count = 0;
    int         space_viol  = 0;
    int         cyc         = 0;
    int         last_start  = -100;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (tx_start_m) begin
            stream.push_back(tx_data_m);
            if (cyc - last_start < 3) space_viol = space_viol + 1;
            last_start = cyc;
        end
        if (done_m)     done_count  = done_count + 1;
        if (rx_clear_m) clear_count = clear_count + 1;
    end

    logic [7:0] exp_stream [12] = '{8'h44, 8'h00, 8'h00, 8'h10, 8'h80, 8'h00,
                                    8'h10, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};

    typedef struct {
        int          sel;
        logic        en;
        int          nbytes;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          exp_tx;
        int          exp_done;
        logic [15:0] exp_fill;
    } vec_t;

    vec_t vecs [7];

    int checks   = 0;
    int failures = 0;
    int base_tx;
    int base_done;
    int base_clr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic mark_base();
        base_tx   = stream.size();
        base_done = done_count;
        base_clr  = clear_count;
    endtask

    // Presents one byte like a real receiver: held until rx_clear is seen.
    task automatic send_byte(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        rx_ready = 1'b1;
        rx_data  = b;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (rx_clear_m) seen = 1'b1;
        end
        rx_ready = 1'b0;
        checkOutput("rx_clear_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_tx(input int target, input int budget, input string name);
        for (int k = 0; k < budget && stream.size() < target; k++) @(negedge clk);
        checkOutput(name, 32'(stream.size() >= target), 32'd1);
    endtask

    task automatic check_full_seq(input string name);
        checkOutput({name, "_count"}, 32'(stream.size() - base_tx), 32'd12);
        for (int j = 0; j < 12; j++) begin
            if (base_tx + j < stream.size())
                checkOutput($sformatf("%s_byte%0d", name, j), 32'(stream[base_tx + j]), 32'(exp_stream[j]));
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        sel    = 2'(v.sel);
        enable = v.en;
        mark_base();
        send_byte(v.b0);
        if (v.nbytes == 2) send_byte(v.b1);
        repeat (60) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{sel:0, en:1'b1, nbytes:1, b0:8'h2E, b1:8'h00, exp_tx:12, exp_done:1, exp_fill:16'd3};
        vecs[1] = '{sel:0, en:1'b1, nbytes:1, b0:8'h41, b1:8'h00, exp_tx:0,  exp_done:0, exp_fill:16'd3};
        vecs[2] = '{sel:0, en:1'b0, nbytes:1, b0:8'h2E, b1:8'h00, exp_tx:0,  exp_done:0, exp_fill:16'd3};
        vecs[3] = '{sel:0, en:1'b1, nbytes:1, b0:8'h2E, b1:8'h00, exp_tx:12, exp_done:1, exp_fill:16'd3};
        vecs[4] = '{sel:1, en:1'b1, nbytes:2, b0:8'h2E, b1:8'h00, exp_tx:12, exp_done:1, exp_fill:16'd3};
        vecs[5] = '{sel:1, en:1'b1, nbytes:2, b0:8'h2E, b1:8'h41, exp_tx:0,  exp_done:0, exp_fill:16'd0};
        vecs[6] = '{sel:1, en:1'b1, nbytes:2, b0:8'h2E, b1:8'h2E, exp_tx:0,  exp_done:0, exp_fill:16'd0};

        rst = 1'b1; enable = 1'b1; abort = 1'b0;
        rx_ready = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; sel = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset_tx_start", 32'(tx_start_m), 32'd0);
        checkOutput("reset_tx_data",  32'(tx_data_m),  32'd0);
        checkOutput("reset_rx_clear", 32'(rx_clear_m), 32'd0);
        checkOutput("reset_busy",     32'(busy_m),     32'd0);
        checkOutput("reset_done",     32'(done_m),     32'd0);
        checkOutput("reset_fill_cnt", 32'(fill_m),     32'd0);

        // First-byte latency: trigger sampled at N, rx_clear at N+1, tx_start at N+2
        begin
            bit ok;
            @(negedge clk);
            rx_ready = 1'b1; rx_data = 8'h2E;
            @(negedge clk);
            rx_ready = 1'b0;
            ok = rx_clear_m && !tx_start_m;
            @(negedge clk);
            ok = ok && tx_start_m && (tx_data_m == 8'h44);
            checkOutput("first_byte_latency", 32'(ok), 32'd1);
            repeat (60) @(negedge clk);
        end

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_tx_count", i), 32'(stream.size() - base_tx), 32'(vecs[i].exp_tx));
            for (int j = 0; j < vecs[i].exp_tx; j++) begin
                if (base_tx + j < stream.size())
                    checkOutput($sformatf("v%0d_byte%0d", i, j), 32'(stream[base_tx + j]), 32'(exp_stream[j]));
            end
            checkOutput($sformatf("v%0d_done", i),  32'(done_count - base_done), 32'(vecs[i].exp_done));
            checkOutput($sformatf("v%0d_fill", i),  32'(fill_m), 32'(vecs[i].exp_fill));
            checkOutput($sformatf("v%0d_busy", i),  32'(busy_m), 32'd0);
            checkOutput($sformatf("v%0d_clear", i), 32'(clear_count - base_clr), 32'(vecs[i].nbytes));
        end

        // Argument timeout: trigger with no follow-up byte
        @(negedge clk);
        sel = 2'd1;
        mark_base();
        send_byte(8'h2E);
        repeat (49990) @(negedge clk);
        checkOutput("timeout_busy_before", 32'(busy_m), 32'd1);
        repeat (20) @(negedge clk);
        checkOutput("timeout_busy_after", 32'(busy_m), 32'd0);
        checkOutput("timeout_no_tx", 32'(stream.size() - base_tx), 32'd0);

        // Unbounded fill, aborted after 20 fill bytes
        @(negedge clk);
        sel = 2'd2;
        mark_base();
        send_byte(8'h2E);
        wait_tx(base_tx + 29, 200, "abort_reach_29");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy_next", 32'(busy_m), 32'd0);
        checkOutput("abort_done_next", 32'(done_m), 32'd0);
        repeat (30) @(negedge clk);
        checkOutput("abort_tx_count", 32'(stream.size() - base_tx), 32'd29);
        checkOutput("abort_fill_cnt", 32'(fill_m), 32'd20);
        checkOutput("abort_no_done", 32'(done_count - base_done), 32'd0);
        if (stream.size() > base_tx + 28)
            checkOutput("abort_last_byte", 32'(stream[base_tx + 28]), 32'hFF);

        // Reset after the 4th header byte, then a clean restart
        @(negedge clk);
        sel = 2'd0;
        mark_base();
        send_byte(8'h2E);
        wait_tx(base_tx + 4, 100, "rst_reach_4");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid_tx_start", 32'(tx_start_m), 32'd0);
        checkOutput("rst_mid_tx_data",  32'(tx_data_m),  32'd0);
        checkOutput("rst_mid_busy",     32'(busy_m),     32'd0);
        checkOutput("rst_mid_fill",     32'(fill_m),     32'd0);
        checkOutput("rst_mid_done",     32'(done_m),     32'd0);
        checkOutput("rst_mid_rx_clear", 32'(rx_clear_m), 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("rst_mid_no_more_tx", 32'(stream.size() - base_tx), 32'd4);
        mark_base();
        send_byte(8'h2E);
        repeat (60) @(negedge clk);
        check_full_seq("rst_restart");

        // Transmitter busy held for 1000 cycles mid-header
        mark_base();
        send_byte(8'h2E);
        wait_tx(base_tx + 3, 100, "txbusy_reach_3");
        tx_busy = 1'b1;
        repeat (1000) @(negedge clk);
        checkOutput("txbusy_held_count", 32'(stream.size() - base_tx), 32'd3);
        checkOutput("txbusy_held_busy", 32'(busy_m), 32'd1);
        tx_busy = 1'b0;
        repeat (60) @(negedge clk);
        check_full_seq("txbusy_release");
        checkOutput("txbusy_done", 32'(done_count - base_done), 32'd1);

        checkOutput("start_spacing_violations", 32'(space_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
